jt89_wrseq: RTL

- Parametrised PSG bus sequencer; generalises the fixed divide-by-4 clock-enable, enable-aligned reset release and hand-written write stimulus used around jt89.
- Queues register-write commands in a FIFO and emits them on the jt89 write port (wr_n/din), with a configurable low time and per-command inter-write gap.
- Generates the PSG clock enable and an enable-aligned PSG reset.
- Sits between a CPU/stimulus master and one jt89 instance.

---
 rtl/jt89_wrseq_pkg.sv | 17 +
 rtl/jt89_wrseq_fifo.sv | 58 +++++
 rtl/jt89_wrseq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/jt89_wrseq_pkg.sv
// Shared definitions for the jt89 write sequencer: FSM encodings and FIFO entry sizing.
package jt89_wrseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int DATA_W = 8;

    // A queued entry is {data byte, wait field}.
    function automatic int entry_width(input int ww);
        return DATA_W + ww;
    endfunction

endpackage

// File: rtl/jt89_wrseq_fifo.sv
// Synchronous show-ahead FIFO for queued PSG write commands, with occupancy level.
module jt89_wrseq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage is left unreset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/jt89_wrseq.sv
// PSG bus sequencer: clock-enable divider, enable-aligned PSG reset and a queued
// write strobe engine driving one jt89 instance.
module jt89_wrseq
    import jt89_wrseq_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int DEPTH = 16,
    parameter int WW    = 8,
    parameter int WRLEN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_data,
    input  logic [WW-1:0]          cmd_wait,
    output logic                   cen,
    output logic                   psg_rst,
    output logic                   wr_n,
    output logic [7:0]             din,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   busy
);
    localparam int EW  = entry_width(WW);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = (WW > $clog2(WRLEN + 1)) ? WW : $clog2(WRLEN + 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [CW-1:0]  WRLEN_M1 = CW'(WRLEN - 1);

    logic [DCW-1:0] div_cnt;
    logic [CW-1:0]  tick_cnt;
    logic [WW-1:0]  wait_q;
    state_t         state;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [EW-1:0]  fifo_rdata;
    logic [7:0]     head_data;
    logic [WW-1:0]  head_wait;

    // cen is registered from the pre-edge count, so it lands one cycle after cnt hits DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            cen     <= 1'b0;
        end else begin
            cen     <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psg_rst <= 1'b1;
        end else if (cen) begin
            psg_rst <= 1'b0;
        end
    end

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = cen && (state == ST_IDLE) && !fifo_empty && !psg_rst;
    assign head_data = fifo_rdata[EW-1:WW];
    assign head_wait = fifo_rdata[WW-1:0];
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (cmd_valid && fifo_full) begin
            ovf <= 1'b1;
        end
    end

    jt89_wrseq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({cmd_data, cmd_wait}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_n     <= 1'b1;
            din      <= 8'h00;
            tick_cnt <= '0;
            wait_q   <= '0;
        end else if (cen) begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        din      <= head_data;
                        wait_q   <= head_wait;
                        wr_n     <= 1'b0;
                        tick_cnt <= WRLEN_M1;
                        state    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (tick_cnt == '0) begin
                        wr_n <= 1'b1;
                        if (wait_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            tick_cnt <= CW'(wait_q - 1'b1);
                            state    <= ST_GAP;
                        end
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
